// File: rtl/prog_timer_counter_pkg.sv
// Shared definitions for the programmable timer/counter: count-mode encodings.
// Pure type package; no logic, no latency, no flow control.
package prog_timer_counter_pkg;

  typedef enum logic [1:0] {
    MODE_FREE    = 2'b00,
    MODE_MODULO  = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

endpackage

// File: rtl/prog_timer_counter_tick_prescaler.sv
// Divides clk down to a one-cycle tick every (prescale+1) enabled cycles.
// Tick is combinational off the registered divider; en low freezes the divider, clear restarts it.
module prog_timer_counter_tick_prescaler #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pre_cnt;

  // Lowering prescale below pre_cnt simply lets the divider wrap round.
  assign tick = en & (pre_cnt == prescale);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (clear || tick) begin
      pre_cnt <= '0;
    end else if (en) begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/prog_timer_counter.sv
// Programmable up/down timer/counter with FREE, MODULO and ONESHOT modes and a terminal-count pulse.
// count/tc/done are registered, one clk after the tick or load; load is accepted regardless of en.
module prog_timer_counter
  import prog_timer_counter_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  dir_down,
  input  logic [1:0]            mode,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  done,
  output logic                  running
);

  mode_e            mode_s;
  logic             tick;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] term_val;
  logic             at_term;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;
  logic             done_nxt;

  assign mode_s  = mode_e'(mode);
  assign running = en & ~done;

  prog_timer_counter_tick_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clear    (load),
    .prescale (prescale),
    .tick     (tick)
  );

  assign step_val = dir_down ? (count - 1'b1) : (count + 1'b1);
  // Reserved mode counts like FREE, so only MODULO/ONESHOT up-counting stops at limit.
  assign term_val = dir_down ? '0 :
                    ((mode_s == MODE_MODULO) || (mode_s == MODE_ONESHOT)) ? limit : '1;
  assign at_term  = (count == term_val);

  always_comb begin
    count_nxt = count;
    tc_nxt    = 1'b0;
    done_nxt  = done;
    if (load) begin
      count_nxt = load_val;
      done_nxt  = 1'b0;
    end else if (tick && !done) begin
      case (mode_s)
        MODE_MODULO: begin
          if (dir_down) begin
            if (count == '0) begin
              count_nxt = limit;
              tc_nxt    = 1'b1;
            end else begin
              count_nxt = step_val;
            end
          end else if (count >= limit) begin
            // Also catches a count left above limit by a load or a limit change.
            count_nxt = '0;
            tc_nxt    = 1'b1;
          end else begin
            count_nxt = step_val;
          end
        end
        MODE_ONESHOT: begin
          if (at_term) begin
            done_nxt = 1'b1;
            tc_nxt   = 1'b1;
          end else begin
            count_nxt = step_val;
          end
        end
        default: begin
          count_nxt = step_val;
          tc_nxt    = at_term;
        end
      endcase
    end else if (done && (mode_s != MODE_ONESHOT)) begin
      done_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      tc    <= 1'b0;
      done  <= 1'b0;
    end else begin
      count <= count_nxt;
      tc    <= tc_nxt;
      done  <= done_nxt;
    end
  end

endmodule
